multicycle_ctrl: RTL and testbench

Multi-cycle control unit driving the existing `data_path` control inputs (`reg_write`, `mem2reg`, `alu_src`, `mem_write`, `mem_read`, `alu_cc`) from the `opcode`/`funct3`/`funct7` fields it returns.

- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Adds instruction-register and PC write enables.
- Adds a ready handshake so data memory may take multiple cycles.
- Flags unsupported encodings.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/ctrl_decode.sv | 57 +++++
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, funct fields, ALU codes, FSM states.
package ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  // Base (funct7 = 0) operation selected by funct3; SUB/SRA are patched in by the decoder.
  function automatic logic [3:0] f3_alu_cc(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: ALU code, B-source select, memory class and illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALU_CC_W = 4
) (
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
  output logic [ALU_CC_W-1:0] alu_cc_o,
  output logic                alu_src_o,
  output logic                is_mem_o,
  output logic                is_load_o,
  output logic                illegal_o
);

  logic [3:0] cc;

  always_comb begin
    cc        = f3_alu_cc(funct3_i);
    alu_src_o = 1'b0;
    is_mem_o  = 1'b0;
    is_load_o = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        if (funct7_i == F7_ALT && funct3_i == F3_ADD)      cc = ALU_SUB;
        else if (funct7_i == F7_ALT && funct3_i == F3_SRL) cc = ALU_SRA;
        else if (funct7_i != F7_BASE)                      illegal_o = 1'b1;
      end
      OP_IALU: begin
        alu_src_o = 1'b1;
        // funct7 only qualifies the shift-immediate forms
        if (funct3_i == F3_SLL) begin
          illegal_o = (funct7_i != F7_BASE);
        end else if (funct3_i == F3_SRL) begin
          if (funct7_i == F7_ALT)       cc = ALU_SRA;
          else if (funct7_i != F7_BASE) illegal_o = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: begin
        alu_src_o = 1'b1;
        is_mem_o  = 1'b1;
        is_load_o = (opcode_i == OP_LOAD);
        cc        = ALU_ADD;
        illegal_o = (funct3_i != F3_WORD);
      end
      default: begin
        cc        = ALU_AND;
        illegal_o = 1'b1;
      end
    endcase
  end

  assign alu_cc_o = ALU_CC_W'(cc);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FSM controller (FETCH/DECODE/EXEC/MEM/WB) with mem_ready stall and sticky illegal trap.
// Optional retired-instruction counter enabled by CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_CC_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_CC_W-1:0] alu_cc,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0]    retired_cnt,
`endif
  output logic                illegal_insn
);

  state_e              state_q;
  logic [16:0]         dec_q;
  logic                ir_write_q, pc_write_q, reg_write_q, mem2reg_q;
  logic                alu_src_q, mem_read_q, mem_write_q, illegal_q;
  logic [ALU_CC_W-1:0] alu_cc_q;

  logic [6:0]          dec_opcode, dec_funct7;
  logic [2:0]          dec_funct3;
  logic [ALU_CC_W-1:0] dec_alu_cc;
  logic                dec_alu_src, dec_is_mem, dec_is_load, dec_illegal;

  // The decoder sees the live fields while they are being captured, the held copy afterwards.
  assign {dec_opcode, dec_funct3, dec_funct7} =
    (state_q == S_DECODE) ? {opcode, funct3, funct7} : dec_q;

  ctrl_decode #(.ALU_CC_W(ALU_CC_W)) u_decode (
    .opcode_i  (dec_opcode),
    .funct3_i  (dec_funct3),
    .funct7_i  (dec_funct7),
    .alu_cc_o  (dec_alu_cc),
    .alu_src_o (dec_alu_src),
    .is_mem_o  (dec_is_mem),
    .is_load_o (dec_is_load),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      dec_q       <= '0;
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_cc_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_cc_q    <= '0;
      case (state_q)
        S_IDLE: begin
          state_q    <= S_FETCH;
          ir_write_q <= 1'b0;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          dec_q <= {opcode, funct3, funct7};
          if (dec_illegal) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q   <= S_EXEC;
            alu_src_q <= dec_alu_src;
            alu_cc_q  <= dec_alu_cc;
          end
        end
        S_EXEC: begin
          if (dec_is_mem) begin
            state_q     <= S_MEM;
            alu_src_q   <= 1'b1;
            alu_cc_q    <= ALU_CC_W'(ALU_ADD);
            mem_read_q  <= dec_is_load;
            mem_write_q <= !dec_is_load;
          end else begin
            state_q     <= S_WB;
            reg_write_q <= 1'b1;
            pc_write_q  <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (mem_read_q) begin
              state_q     <= S_WB;
              reg_write_q <= 1'b1;
              pc_write_q  <= 1'b1;
              mem2reg_q   <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              ir_write_q <= 1'b1;
            end
          end else begin
            alu_src_q   <= 1'b1;
            alu_cc_q    <= ALU_CC_W'(ALU_ADD);
            mem_read_q  <= mem_read_q;
            mem_write_q <= mem_write_q;
          end
        end
        S_WB: begin
          state_q    <= S_FETCH;
          ir_write_q <= 1'b1;
        end
        default: state_q <= S_TRAP;
      endcase
      // IDLE leads into FETCH, which always raises ir_write for one cycle
      if (state_q == S_IDLE) ir_write_q <= 1'b1;
    end
  end

  assign ir_write     = ir_write_q;
  assign pc_write     = pc_write_q | (mem_write_q & mem_ready);
  assign reg_write    = reg_write_q;
  assign mem2reg      = mem2reg_q;
  assign alu_src      = alu_src_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign alu_cc       = alu_cc_q;
  assign illegal_insn = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt_q <= '0;
    else if (pc_write) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign retired_cnt = cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; counter checks compile in with CTRL_PERF_CNT_EN.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write, reg_write, mem2reg, alu_src, mem_read, mem_write, illegal_insn;
  logic [3:0] alu_cc;
`ifdef CTRL_PERF_CNT_EN
  logic [3:0] retired_cnt;
  logic [3:0] exp_cnt = '0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .mem_ready    (mem_ready),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .mem2reg      (mem2reg),
    .alu_src      (alu_src),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .alu_cc       (alu_cc),
`ifdef CTRL_PERF_CNT_EN
    .retired_cnt  (retired_cnt),
`endif
    .illegal_insn (illegal_insn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ir, pc, reg, m2r, src, mrd, mwr, cc[3:0], illegal}
  function automatic logic [31:0] outs();
    return {20'b0, ir_write, pc_write, reg_write, mem2reg, alu_src, mem_read, mem_write,
            alu_cc, illegal_insn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_insn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Called while sampling FETCH; leaves the bench sampling the next FETCH.
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] exp_cc, input logic exp_src);
    int start;
    start = cyc;
    set_insn(op, f3, f7);
    step();
    chk({tag, "_decode_quiet"}, outs(), 32'h000);
    step();
    chk({tag, "_exec_cc"}, alu_cc, exp_cc);
    chk({tag, "_exec_src"}, alu_src, exp_src);
    step();
    chk({tag, "_wb"}, {reg_write, pc_write, mem2reg, alu_cc}, {3'b110, 4'b0000});
    step();
    chk({tag, "_fetch"}, ir_write, 1'b1);
    chk({tag, "_cycles"}, cyc - start, 4);
`ifdef CTRL_PERF_CNT_EN
    exp_cnt++;
`endif
  endtask

  task automatic release_reset(input string tag);
    reset = 1'b1;
    chk({tag, "_idle"}, outs(), 32'h000);
    step();
    chk({tag, "_fetch"}, outs(), 32'h800);
  endtask

  initial begin
    int start;
    int nrd;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_low_outs", outs(), 32'h000);
    end
    release_reset("release");

    run_alu("add",  7'b0110011, 3'b000, 7'b0000000, 4'b0010, 1'b0);
    run_alu("sub",  7'b0110011, 3'b000, 7'b0100000, 4'b0110, 1'b0);
    run_alu("ori",  7'b0010011, 3'b110, 7'b1010101, 4'b0001, 1'b1);
    run_alu("srai", 7'b0010011, 3'b101, 7'b0100000, 4'b1000, 1'b1);

    // LW with three stalled MEM cycles
    start = cyc;
    nrd = 0;
    set_insn(7'b0000011, 3'b010, 7'b0000000);
    mem_ready = 1'b0;
    step();
    step();
    chk("lw_exec", {alu_src, alu_cc, mem_read}, {1'b1, 4'b0010, 1'b0});
    step();
    for (int i = 0; i < 4; i++) begin
      if (mem_read) nrd++;
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      chk("lw_mem_no_pc", {pc_write, reg_write, alu_src, alu_cc}, {2'b00, 1'b1, 4'b0010});
      step();
    end
    mem_ready = 1'b0;
    chk("lw_read_cycles", nrd, 4);
    chk("lw_wb", {reg_write, pc_write, mem2reg, mem_read}, 4'b1110);
    step();
    chk("lw_fetch", ir_write, 1'b1);
    chk("lw_cycles", cyc - start, 8);
`ifdef CTRL_PERF_CNT_EN
    exp_cnt++;
`endif

    // SW with mem_ready already high
    start = cyc;
    set_insn(7'b0100011, 3'b010, 7'b0000000);
    mem_ready = 1'b1;
    step();
    chk("sw_decode", {pc_write, mem_write, reg_write}, 3'b000);
    step();
    chk("sw_exec", {pc_write, mem_write, reg_write, alu_src}, 4'b0001);
    step();
    chk("sw_mem", {mem_write, pc_write, reg_write}, 3'b110);
    step();
    mem_ready = 1'b0;
    chk("sw_fetch", {ir_write, mem_write, reg_write}, 3'b100);
    chk("sw_cycles", cyc - start, 4);
`ifdef CTRL_PERF_CNT_EN
    exp_cnt++;
    chk("cnt_after_sw", retired_cnt, exp_cnt);
    for (int i = 0; i < 9; i++) run_alu("andi", 7'b0010011, 3'b111, 7'b0000000, 4'b0000, 1'b1);
    chk("cnt_all_ones", retired_cnt, 4'hF);
    run_alu("xor", 7'b0110011, 3'b100, 7'b0000000, 4'b0011, 1'b0);
    chk("cnt_wrap", retired_cnt, 4'h0);
`endif

    // Reset arriving mid-MEM with a read outstanding
    set_insn(7'b0000011, 3'b010, 7'b0000000);
    step();
    step();
    step();
    chk("midmem_read", mem_read, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("midmem_reset_outs", outs(), 32'h000);
`ifdef CTRL_PERF_CNT_EN
    chk("midmem_reset_cnt", retired_cnt, 4'h0);
`endif
    step();
    release_reset("rerelease");

    // Branch opcode traps
    set_insn(7'b1100011, 3'b000, 7'b0000000);
    step();
    step();
    chk("branch_trap", outs(), 32'h001);
    for (int i = 0; i < 6; i++) begin
      mem_ready = i[0];
      step();
      chk("branch_trap_sticky", outs(), 32'h001);
    end
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("trap_reset_clears", illegal_insn, 1'b0);
    step();
    release_reset("trap_release");

    // LW with wrong funct3 traps
    set_insn(7'b0000011, 3'b000, 7'b0000000);
    step();
    step();
    chk("lw_f3_trap", outs(), 32'h001);
    mem_ready = 1'b1;
    step();
    step();
    chk("lw_f3_sticky", outs(), 32'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
